// File: rtl/sprite_draw_engine.sv
// Rectangular sprite plotter: streams a filled SPR_W x SPR_H block, then a one-pixel
// background strip on the trailing edge, one pixel per clock into the VGA adapter.
module sprite_draw_engine #(
    parameter int SPR_W       = 4,
    parameter int SPR_H       = 4,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int COLOUR_BITS = 3,
    parameter int BG_COLOUR   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   start,
    input  logic [7:0]             sprite_x,
    input  logic [6:0]             sprite_y,
    input  logic [COLOUR_BITS-1:0] colour,
    input  logic [2:0]             move_dir,
    output logic [7:0]             x_out,
    output logic [6:0]             y_out,
    output logic [COLOUR_BITS-1:0] colour_out,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    localparam int MAX_DIM = (SPR_W > SPR_H) ? SPR_W : SPR_H;
    localparam int CW      = $clog2(MAX_DIM) + 1;

    localparam logic [CW-1:0] W_LAST  = CW'(SPR_W - 1);
    localparam logic [CW-1:0] H_LAST  = CW'(SPR_H - 1);
    // A -1 step is an add of SCREEN-1 followed by the same conditional subtract.
    localparam logic [7:0]    X_LEFT  = 8'(SCREEN_W - 1);
    localparam logic [7:0]    X_RIGHT = 8'(SPR_W);
    localparam logic [6:0]    Y_UP    = 7'(SCREEN_H - 1);
    localparam logic [6:0]    Y_DOWN  = 7'(SPR_H);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_ERASE, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [7:0]             ox_q, ox_d;
    logic [6:0]             oy_q, oy_d;
    logic [COLOUR_BITS-1:0] fc_q, fc_d;
    logic [2:0]             dir_q, dir_d;
    logic [CW-1:0]          col_q, col_d;
    logic [CW-1:0]          row_q, row_d;
    logic [7:0]             x_out_q, x_out_d;
    logic [6:0]             y_out_q, y_out_d;
    logic [COLOUR_BITS-1:0] colour_out_q, colour_out_d;
    logic                   plot_q, plot_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   strip_last;

    function automatic logic [7:0] wrap_x(input logic [7:0] org, input logic [7:0] off);
        logic [8:0] sum;
        sum = {1'b0, org} + {1'b0, off};
        if (sum >= 9'(SCREEN_W)) sum = sum - 9'(SCREEN_W);
        return sum[7:0];
    endfunction

    function automatic logic [6:0] wrap_y(input logic [6:0] org, input logic [6:0] off);
        logic [7:0] sum;
        sum = {1'b0, org} + {1'b0, off};
        if (sum >= 8'(SCREEN_H)) sum = sum - 8'(SCREEN_H);
        return sum[6:0];
    endfunction

    always_comb begin
        state_d      = state_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        fc_d         = fc_q;
        dir_d        = dir_q;
        col_d        = col_q;
        row_d        = row_q;
        x_out_d      = x_out_q;
        y_out_d      = y_out_q;
        colour_out_d = colour_out_q;
        plot_d       = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        strip_last   = (dir_q == 3'd1 || dir_q == 3'd2) ? (col_q == H_LAST) : (col_q == W_LAST);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ox_d    = sprite_x;
                    oy_d    = sprite_y;
                    fc_d    = colour;
                    dir_d   = (move_dir > 3'd4) ? 3'd0 : move_dir;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                busy_d       = 1'b1;
                plot_d       = 1'b1;
                x_out_d      = wrap_x(ox_q, 8'(col_q));
                y_out_d      = wrap_y(oy_q, 7'(row_q));
                colour_out_d = fc_q;
                // Column-major walk: rows step fastest.
                if (row_q == H_LAST) begin
                    row_d = '0;
                    if (col_q == W_LAST) begin
                        col_d   = '0;
                        state_d = (dir_q == 3'd0) ? S_DONE : S_ERASE;
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end else begin
                    row_d = row_q + CW'(1);
                end
            end
            S_ERASE: begin
                busy_d       = 1'b1;
                plot_d       = 1'b1;
                colour_out_d = COLOUR_BITS'(BG_COLOUR);
                case (dir_q)
                    3'd1: begin
                        x_out_d = wrap_x(ox_q, X_LEFT);
                        y_out_d = wrap_y(oy_q, 7'(col_q));
                    end
                    3'd2: begin
                        x_out_d = wrap_x(ox_q, X_RIGHT);
                        y_out_d = wrap_y(oy_q, 7'(col_q));
                    end
                    3'd3: begin
                        x_out_d = wrap_x(ox_q, 8'(col_q));
                        y_out_d = wrap_y(oy_q, Y_UP);
                    end
                    default: begin
                        x_out_d = wrap_x(ox_q, 8'(col_q));
                        y_out_d = wrap_y(oy_q, Y_DOWN);
                    end
                endcase
                if (strip_last) begin
                    col_d   = '0;
                    state_d = S_DONE;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (clear) begin
            state_d = S_IDLE;
            col_d   = '0;
            row_d   = '0;
            plot_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            ox_q         <= '0;
            oy_q         <= '0;
            fc_q         <= '0;
            dir_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            x_out_q      <= '0;
            y_out_q      <= '0;
            colour_out_q <= '0;
            plot_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            fc_q         <= fc_d;
            dir_q        <= dir_d;
            col_q        <= col_d;
            row_q        <= row_d;
            x_out_q      <= x_out_d;
            y_out_q      <= y_out_d;
            colour_out_q <= colour_out_d;
            plot_q       <= plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign x_out      = x_out_q;
    assign y_out      = y_out_q;
    assign colour_out = colour_out_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: doc/sprite_draw_engine.md
# sprite_draw_engine

Parametrised rectangular sprite plotter for the 160x120 VGA adapter path. A single start command latches a sprite origin, colour and movement direction. The block then streams one pixel per clock into the adapter: first the W x H filled rectangle, then a one-pixel-wide erase strip of background colour along the sprite's trailing edge. It generalises the per-enemy fixed 4x4 drawers to any sprite size, any move direction, an explicit plot strobe and a clean done pulse. It sits between the game FSM/datapath and the VGA adapter's x/y/colour/plot inputs.

## Interface
- SPR_W, 4, sprite width in pixels (1..16)
- SPR_H, 4, sprite height in pixels (1..16)
- SCREEN_W, 160, horizontal wrap modulus
- SCREEN_H, 120, vertical wrap modulus
- COLOUR_BITS, 3, pixel colour width
- BG_COLOUR, 0, colour used for erase strip

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- clear  in  1  synchronous abort (game restart); highest priority after reset
- start  in  1  draw request, sampled only in IDLE
- sprite_x  in  8  origin x, caller guarantees < SCREEN_W
- sprite_y  in  7  origin y, caller guarantees < SCREEN_H
- colour  in  COLOUR_BITS  fill colour
- move_dir  in  3  0 none, 1 moved right, 2 moved left, 3 moved down, 4 moved up, 5..7 treated as none
- x_out  out  8  pixel x to adapter
- y_out  out  7  pixel y to adapter
- colour_out  out  COLOUR_BITS  pixel colour to adapter
- plot  out  1  pixel write enable; x_out/y_out/colour_out valid only when high
- busy  out  1  high from cycle after accepted start through DONE state
- done  out  1  one-cycle pulse after final pixel

## Operation
- States: IDLE, FILL, ERASE, DONE.
- IDLE: start=1 latches sprite_x, sprite_y, colour and move_dir. The FSM then goes to FILL and clears the column and row counters. Inputs are not re-sampled until the next IDLE.
- FILL: emits SPR_W*SPR_H pixels in column-major order (y offset increments fastest, then x offset) with colour_out = latched colour.
  - After the last pixel, go to ERASE if move_dir is 1..4, else to DONE.
- ERASE: emits one trailing strip with colour_out = BG_COLOUR.
  - dir 1: column x-1, rows y..y+SPR_H-1.
  - dir 2: column x+SPR_W, rows y..y+SPR_H-1.
  - dir 3: row y-1, columns x..x+SPR_W-1.
  - dir 4: row y+SPR_H, columns x..x+SPR_W-1.
  - Strip order is ascending offset. After the last strip pixel, go to DONE.
- DONE: done=1 for exactly one cycle, plot=0, then IDLE.
- Coordinate arithmetic: every emitted coordinate is (origin + offset) mod SCREEN_W or SCREEN_H. Negative offsets (-1) wrap to SCREEN-1.
  - Implement with a widened add and a single conditional subtract or add. No `%` on non-powers of two.
- Counter widths are $clog2 of the maximum count plus 1. There is no overflow for any legal parameter.
- start while busy: ignored, no queueing.
- clear=1 in any state:
  - Next state is IDLE.
  - plot, busy and done are 0.
  - The partial sprite is abandoned and no done pulse is produced.
- clear and start high in the same cycle: clear wins and nothing is latched.
- reset low at any time:
  - All registers go to 0 immediately; FSM goes to IDLE.
  - x_out=0, y_out=0, colour_out=0, plot=0, busy=0, done=0.

## Timing
- Outputs are registered; plot is aligned with its coordinates and colour.
- start accepted at edge 0. Fill pixels appear in cycles 1..N, where N=SPR_W*SPR_H.
- Erase pixels appear in cycles N+1..N+L, where L = SPR_H for dir 1/2, SPR_W for dir 3/4, and 0 otherwise.
- done appears in cycle N+L+1. The block is back in IDLE and able to accept start in cycle N+L+2.
- busy is high in cycles 1..N+L+1.
- Throughput: one pixel per clock with no bubbles between FILL and ERASE.
- After reset deasserts, the earliest start is accepted on the first clock edge.

## Test plan
- 4x4 at (10,20), colour 5, dir 1:
  - Cycles 1..16 plot (10..13, 20..23) column-major, colour 5.
  - Cycles 17..20 plot x=9, y=20..23, colour 0.
  - done pulse at cycle 21, busy low at cycle 22.
- Wrap: 4x4 at (158,118), dir 2:
  - Fill x sequence 158,159,0,1; y sequence 118,119,0,1.
  - Erase column x=2; origin (0,0) with dir 1 erases x=159.
- Vertical: SPR_W=3, SPR_H=2 at (50,60), dir 4:
  - 6 fill pixels, then erase y=62, x=50,51,52.
  - done at cycle 10.
- Protocol: start pulsed again at cycle 5 of a draw is ignored, giving a single done. A new start the cycle after IDLE is entered is accepted.
- Abort:
  - clear at cycle 7 gives plot=0 from cycle 8 and no done; a fresh start then draws from offset 0.
  - reset low mid-FILL drops all outputs to 0 asynchronously.
- Degenerate: SPR_W=SPR_H=1, dir 0, at (0,0): one pixel at cycle 1, done at cycle 2.
